// File: rtl/riscv_dmem_responder.sv
// In-order data-memory responder: word RAM behind a fixed-latency response pipe plus a
// flush/invalidate busy sequencer. Define RISCV_DMEM_STALL_INJECT_EN for LFSR accept stalls.
module riscv_dmem_responder #(
   parameter int unsigned MEM_AW       = 12,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned LATENCY      = 1,
   parameter int unsigned MAINT_CYCLES = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_wr_i,
   input  logic        mem_rd_i,
   input  logic [3:0]  mem_wr_i,
   input  logic        mem_cacheable_i,
   input  logic [10:0] mem_req_tag_i,
   input  logic        mem_invalidate_i,
   input  logic        mem_flush_i,
   output logic [31:0] mem_data_rd_o,
   output logic        mem_accept_o,
   output logic        mem_ack_o,
   output logic        mem_error_o,
   output logic [10:0] mem_resp_tag_o
);

   localparam int unsigned WORDS = 1 << MEM_AW;
   localparam logic [32:0] RANGE = 33'(1) << (MEM_AW + 2);
   localparam int unsigned CW    = $clog2(MAINT_CYCLES + 1);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $fatal(1, "riscv_dmem_responder: LATENCY must be in 1..4");
   end
   if (MAINT_CYCLES == 0) begin : g_bad_maint
      $fatal(1, "riscv_dmem_responder: MAINT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      MAINT,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     busy_cnt;
   logic [CW-1:0]     busy_cnt_next;
   logic [10:0]       maint_tag;

   logic              maint_req;
   logic              wr_req;
   logic              rd_req;
   logic              req;
   logic              accept;
   logic              xfer;
   logic              pipe_xfer;
   logic              stall;
   logic [31:0]       offset;
   logic              in_range;
   logic [MEM_AW-1:0] idx;

   logic [31:0]        ram [WORDS];
   logic [LATENCY-1:0] pipe_valid;
   logic [LATENCY-1:0] pipe_err;
   logic [10:0]        pipe_tag  [LATENCY];
   logic [31:0]        pipe_data [LATENCY];
   logic               pipe_busy;

   logic unused_cacheable;
   assign unused_cacheable = mem_cacheable_i;

   // Maintenance beats write, write beats read, so each accepted request has one kind.
   assign maint_req = mem_invalidate_i | mem_flush_i;
   assign wr_req    = (mem_wr_i != 4'b0000) & ~maint_req;
   assign rd_req    = mem_rd_i & ~maint_req & (mem_wr_i == 4'b0000);
   assign req       = maint_req | wr_req | rd_req;
   assign xfer      = req & accept;
   assign pipe_xfer = xfer & ~maint_req;

   assign offset   = mem_addr_i - BASE_ADDR;
   assign in_range = {1'b0, offset} < RANGE;
   assign idx      = offset[MEM_AW+1:2];

`ifdef RISCV_DMEM_STALL_INJECT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Byte-lane write at the accept edge; RAM contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (xfer && wr_req && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wr_i[b]) begin
               ram[idx][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
            end
         end
      end
   end

   // Stage 0 captures the response at the accept edge; later stages only delay it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_tag[i]  <= '0;
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= pipe_xfer;
         pipe_err[0]   <= pipe_xfer & ~in_range;
         pipe_tag[0]   <= pipe_xfer ? mem_req_tag_i : 11'd0;
         pipe_data[0]  <= (xfer && rd_req && in_range) ? ram[idx] : 32'd0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_tag[i]   <= pipe_tag[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   assign pipe_busy = |pipe_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         busy_cnt  <= '0;
         maint_tag <= '0;
      end else begin
         state    <= state_next;
         busy_cnt <= busy_cnt_next;
         if (xfer && maint_req) begin
            maint_tag <= mem_req_tag_i;
         end
      end
   end

   // MAINT holds until the counter expires and the pipe drains, so DONE never overlaps a pipe ack.
   always_comb begin
      state_next    = state;
      busy_cnt_next = busy_cnt;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            accept = ~rst_i & ~stall;
            if (req && accept && maint_req) begin
               state_next    = MAINT;
               busy_cnt_next = CW'(MAINT_CYCLES);
            end
         end
         MAINT: begin
            if (busy_cnt != '0) begin
               busy_cnt_next = busy_cnt - CW'(1);
            end else if (!pipe_busy) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_accept_o = accept;

   always_comb begin
      mem_ack_o      = 1'b0;
      mem_error_o    = 1'b0;
      mem_data_rd_o  = 32'd0;
      mem_resp_tag_o = 11'd0;
      if (!rst_i) begin
         if (pipe_valid[LATENCY-1]) begin
            mem_ack_o      = 1'b1;
            mem_error_o    = pipe_err[LATENCY-1];
            mem_data_rd_o  = pipe_data[LATENCY-1];
            mem_resp_tag_o = pipe_tag[LATENCY-1];
         end else if (state == DONE) begin
            mem_ack_o      = 1'b1;
            mem_resp_tag_o = maint_tag;
         end
      end
   end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Self-checking bench for riscv_dmem_responder: vector table plus scoreboard of expected acks,
// with hand sequences for maintenance busy periods and reset with requests in flight.
`timescale 1ns/1ps
module tb_riscv_dmem_responder;

   localparam int LAT   = 3;
   localparam int MAINT = 8;
   localparam int AW    = 12;
   localparam int NV    = 21;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_wr_i;
   logic        mem_rd_i;
   logic [3:0]  mem_wr_i;
   logic        mem_cacheable_i;
   logic [10:0] mem_req_tag_i;
   logic        mem_invalidate_i;
   logic        mem_flush_i;
   logic [31:0] mem_data_rd_o;
   logic        mem_accept_o;
   logic        mem_ack_o;
   logic        mem_error_o;
   logic [10:0] mem_resp_tag_o;

   riscv_dmem_responder #(
      .MEM_AW(AW),
      .BASE_ADDR(32'h0000_0000),
      .LATENCY(LAT),
      .MAINT_CYCLES(MAINT)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .mem_addr_i(mem_addr_i),
      .mem_data_wr_i(mem_data_wr_i),
      .mem_rd_i(mem_rd_i),
      .mem_wr_i(mem_wr_i),
      .mem_cacheable_i(mem_cacheable_i),
      .mem_req_tag_i(mem_req_tag_i),
      .mem_invalidate_i(mem_invalidate_i),
      .mem_flush_i(mem_flush_i),
      .mem_data_rd_o(mem_data_rd_o),
      .mem_accept_o(mem_accept_o),
      .mem_ack_o(mem_ack_o),
      .mem_error_o(mem_error_o),
      .mem_resp_tag_o(mem_resp_tag_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic [3:0]  wr;
      logic        inv;
      logic        flush;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [10:0] tag;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic [10:0] tag;
      logic        err;
      logic [31:0] data;
      int          due;
   } exp_t;

   vec_t vecs [NV];
   exp_t sb [$];
   exp_t got;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Every negedge: pop and compare an ack, flag overdue or unexpected acks, else require zeroed fields.
   always @(negedge clk_i) begin
      if (mem_ack_o) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_ack: got ack=1 tag=%0h, required ack=0 (cycle %0d)", mem_resp_tag_o, cyc);
         end else begin
            got = sb.pop_front();
            checkOutput("ack_tag", 64'(mem_resp_tag_o), 64'(got.tag));
            checkOutput("ack_error", 64'(mem_error_o), 64'(got.err));
            checkOutput("ack_data", 64'(mem_data_rd_o), 64'(got.data));
            checkOutput("ack_cycle", 64'(cyc), 64'(got.due));
         end
      end else begin
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            got = sb.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing_ack: got ack=0, required ack tag=%0h at cycle %0d", got.tag, got.due);
         end
         checkOutput("idle_fields", {20'd0, mem_error_o, mem_resp_tag_o, mem_data_rd_o}, 64'd0);
      end
   end

   task automatic setIdle();
      mem_addr_i       = 32'd0;
      mem_data_wr_i    = 32'd0;
      mem_rd_i         = 1'b0;
      mem_wr_i         = 4'd0;
      mem_cacheable_i  = 1'b0;
      mem_req_tag_i    = 11'd0;
      mem_invalidate_i = 1'b0;
      mem_flush_i      = 1'b0;
   endtask

   // Called just after a posedge; holds the request until accepted and returns the accept-negedge cycle.
   task automatic applyStimulus(input vec_t v, input bit track, output int acc);
      exp_t e;
      mem_addr_i       = v.addr;
      mem_data_wr_i    = v.wdata;
      mem_rd_i         = v.rd;
      mem_wr_i         = v.wr;
      mem_cacheable_i  = 1'b1;
      mem_req_tag_i    = v.tag;
      mem_invalidate_i = v.inv;
      mem_flush_i      = v.flush;
      acc = -1;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk_i);
         if (mem_accept_o) begin
            acc = cyc;
            break;
         end
         @(posedge clk_i);
         #1;
      end
      if (acc < 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: got accept=0 for 64 cycles, required 1 (tag %0h)", v.tag);
      end else if (track) begin
         e.tag  = v.tag;
         e.err  = v.exp_err;
         e.data = v.exp_data;
         // Maintenance: MAINT_CYCLES+1 cycles in MAINT (counter value down to 0), then one DONE cycle.
         e.due  = (v.inv || v.flush) ? acc + MAINT + 2 : acc + LAT;
         sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
      setIdle();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk_i);
         n++;
      end
      checkOutput("drain_empty", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a;
      int fa;
      int ra;
      vec_t v;

      //              rd    wr     inv   flush addr           wdata          tag      err   data
      vecs[0]  = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 11'h005, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        11'h205, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_0020, 32'h11223344, 11'h006, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 4'h4, 1'b0, 1'b0, 32'h0000_0020, 32'h00AA0000, 11'h007, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,        11'h008, 1'b0, 32'h11AA3344};
      vecs[5]  = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_4000, 32'h0,        11'h201, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_4010, 32'h55555555, 11'h202, 1'b1, 32'h0};
      vecs[7]  = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        11'h203, 1'b0, 32'hDEADBEEF};
      vecs[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0023, 32'h0,        11'h204, 1'b0, 32'h11AA3344};
      vecs[9]  = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_0030, 32'hCAFEF00D, 11'h3FF, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 4'h3, 1'b0, 1'b0, 32'h0000_0030, 32'h12345678, 11'h400, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 4'hF, 1'b0, 1'b0, 32'h0000_0040, 32'h0BADF00D, 11'h7FF, 1'b0, 32'h0};
      vecs[12] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        11'h001, 1'b0, 32'h0BADF00D};
      vecs[13] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0030, 32'h0,        11'h002, 1'b0, 32'hCAFE5678};
      vecs[14] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,        11'h003, 1'b0, 32'h11AA3344};
      vecs[15] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        11'h004, 1'b0, 32'hDEADBEEF};
      vecs[16] = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_3FFC, 32'hA5A55A5A, 11'h100, 1'b0, 32'h0};
      vecs[17] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_3FFF, 32'h0,        11'h101, 1'b0, 32'hA5A55A5A};
      vecs[18] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        11'h102, 1'b1, 32'h0};
      vecs[19] = '{1'b0, 4'h9, 1'b0, 1'b0, 32'h0000_3FFC, 32'h11000022, 11'h103, 1'b0, 32'h0};
      vecs[20] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_3FFC, 32'h0,        11'h104, 1'b0, 32'h11A55A22};

      setIdle();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset_accept", 64'(mem_accept_o), 64'd0);
      checkOutput("reset_ack", 64'(mem_ack_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("post_reset_accept", 64'(mem_accept_o), 64'd1);
      @(posedge clk_i);
      #1;

      $display("[TB] vector table: %0d back-to-back requests", NV);
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i], 1'b1, a);
      end
      drain();

      $display("[TB] flush with a read held pending during the busy period");
      v = '{1'b0, 4'h0, 1'b0, 1'b1, 32'h0, 32'h0, 11'h011, 1'b0, 32'h0};
      applyStimulus(v, 1'b1, fa);
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 11'h0AB, 1'b0, 32'hDEADBEEF};
      applyStimulus(v, 1'b1, ra);
      checkOutput("flush_accept_gap", 64'(ra), 64'(fa + MAINT + 3));
      drain();

      $display("[TB] invalidate with strobes set, right behind an in-flight read");
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 11'h020, 1'b0, 32'h0BADF00D};
      applyStimulus(v, 1'b1, a);
      v = '{1'b0, 4'hF, 1'b1, 1'b0, 32'h0000_0020, 32'hFFFFFFFF, 11'h012, 1'b0, 32'h0};
      applyStimulus(v, 1'b1, fa);
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 11'h013, 1'b0, 32'h11AA3344};
      applyStimulus(v, 1'b1, ra);
      checkOutput("inval_accept_gap", 64'(ra), 64'(fa + MAINT + 3));
      drain();

      $display("[TB] reset with two reads in flight");
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 11'h031, 1'b0, 32'h0};
      applyStimulus(v, 1'b0, a);
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 11'h032, 1'b0, 32'h0};
      applyStimulus(v, 1'b0, a);
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("midrun_reset_accept", 64'(mem_accept_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("release_accept", 64'(mem_accept_o), 64'd1);
      repeat (8) @(posedge clk_i);
      #1;
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 11'h033, 1'b0, 32'hDEADBEEF};
      applyStimulus(v, 1'b1, a);
      v = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 11'h034, 1'b0, 32'hCAFE5678};
      applyStimulus(v, 1'b1, a);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
